// File: rtl/memory_bus_write_sequencer_pkg.sv
// Shared encodings, control-register addresses and the write-port record for the
// memory bus write sequencer.
package memory_bus_write_sequencer_pkg;

  localparam logic [1:0] BRAM_SELECT_CONTROLLER = 2'h0;
  localparam logic [1:0] BRAM_SELECT_MOD        = 2'h1;
  localparam logic [1:0] BRAM_SELECT_PWE        = 2'h2;
  localparam logic [1:0] BRAM_SELECT_STM        = 2'h3;

  localparam logic [13:0] ADDR_MOD_MEM_WR_SEGMENT = 14'h0020;
  localparam logic [13:0] ADDR_STM_MEM_WR_SEGMENT = 14'h0021;
  localparam logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0022;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [15:0] din;
  } bram_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } wr_state_e;

  function automatic bram_wr_t make_wr(input logic we, input logic [13:0] addr,
                                       input logic [15:0] din);
    bram_wr_t w;
    w.we   = we;
    w.addr = addr;
    w.din  = din;
    return w;
  endfunction

endpackage

// File: rtl/memory_bus_write_detect.sv
// Registers the CPU bus once and turns each EN&WE assertion into a single commit
// cycle carrying the captured select, address and data.
//   state     | meaning
//   ST_IDLE   | waiting for a fresh EN&WE assertion
//   ST_COMMIT | one cycle; captured write is presented downstream
//   ST_HOLD   | write done; waiting for EN or WE to drop
module memory_bus_write_detect
  import memory_bus_write_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [13:0] addr,
  input  logic [15:0] din,
  output logic [1:0]  commit_sel,
  output bram_wr_t    commit_wr
);

  wr_state_e   state_q, state_d;
  logic        en_q, we_q;
  logic [1:0]  sel_q, cap_sel_q;
  logic [13:0] addr_q, cap_addr_q;
  logic [15:0] din_q, cap_din_q;
  logic        armed_q, armed_d;
  logic        wr_q;
  logic        capture;

  assign wr_q = en_q & we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      cap_sel_q  <= '0;
      cap_addr_q <= '0;
      cap_din_q  <= '0;
      armed_q    <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      en_q    <= en;
      we_q    <= we;
      sel_q   <= sel;
      addr_q  <= addr;
      din_q   <= din;
      armed_q <= armed_d;
      state_q <= state_d;
      if (capture) begin
        cap_sel_q  <= sel_q;
        cap_addr_q <= addr_q;
        cap_din_q  <= din_q;
      end
    end
  end

  // Re-arming needs the raw bus seen idle, so a write held across reset is not replayed.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~(en & we);
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_q && armed_q) begin
          state_d = ST_COMMIT;
          armed_d = ~(en & we);
          capture = 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!wr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit_sel = cap_sel_q;
  assign commit_wr  = make_wr(state_q == ST_COMMIT, cap_addr_q, cap_din_q);

endmodule

// File: rtl/memory_bus_write_sequencer.sv
// CPU bus to BRAM write-port sequencer: segment/page shadows, target decode and
// controller-port arbitration. Optional range check: MEM_BUS_ADDR_CHECK_EN.
module memory_bus_write_sequencer
  import memory_bus_write_sequencer_pkg::*;
#(
  parameter int STM_PAGE_W = 4,
  parameter int PWE_DEPTH  = 128,
  parameter int MOD_DEPTH  = 16384
) (
  input  logic                    BUS_CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    WE,
  input  logic [1:0]              BRAM_SELECT,
  input  logic [13:0]             BRAM_ADDR,
  input  logic [15:0]             DATA_IN,
  input  logic                    INT_REQ,
  input  logic [13:0]             INT_ADDR,
  input  logic [15:0]             INT_DATA,
  output logic                    INT_GNT,
  output logic                    CNT_WE,
  output logic [13:0]             CNT_ADDR,
  output logic [15:0]             CNT_DIN,
  output logic                    MOD_WE,
  output logic [$clog2(MOD_DEPTH):0] MOD_ADDR,
  output logic [15:0]             MOD_DIN,
  output logic                    STM_WE,
  output logic [14+STM_PAGE_W:0]  STM_ADDR,
  output logic [15:0]             STM_DIN,
  output logic                    PWE_WE,
  output logic [$clog2(PWE_DEPTH)-1:0] PWE_ADDR,
  output logic [15:0]             PWE_DIN,
  output logic                    ADDR_ERR
);

  localparam int MOD_AW = $clog2(MOD_DEPTH);
  localparam int PWE_AW = $clog2(PWE_DEPTH);

  logic [1:0]              c_sel;
  bram_wr_t                c_wr;
  bram_wr_t                cnt_q;
  logic                    int_gnt_q;
  logic                    mod_we_q, stm_we_q, pwe_we_q;
  logic [MOD_AW:0]         mod_addr_q;
  logic [14+STM_PAGE_W:0]  stm_addr_q;
  logic [PWE_AW-1:0]       pwe_addr_q;
  logic [15:0]             mod_din_q, stm_din_q, pwe_din_q;
  logic                    mod_seg_q, stm_seg_q;
  logic [STM_PAGE_W-1:0]   stm_page_q;
  logic                    bus_cnt, int_take;
  logic                    pwe_oob, mod_oob;

  memory_bus_write_detect u_detect (
    .clk        (BUS_CLK),
    .rst_n      (RST_N),
    .en         (EN),
    .we         (WE),
    .sel        (BRAM_SELECT),
    .addr       (BRAM_ADDR),
    .din        (DATA_IN),
    .commit_sel (c_sel),
    .commit_wr  (c_wr)
  );

`ifdef MEM_BUS_ADDR_CHECK_EN
  assign pwe_oob = 32'(c_wr.addr) >= PWE_DEPTH;
  assign mod_oob = 32'(c_wr.addr) >= MOD_DEPTH;
`else
  assign pwe_oob = 1'b0;
  assign mod_oob = 1'b0;
`endif

  // Bus owns the controller port on its commit cycle; the internal requester
  // is skipped on the grant cycle so a held request is not granted twice.
  assign bus_cnt  = c_wr.we && (c_sel == BRAM_SELECT_CONTROLLER);
  assign int_take = INT_REQ && !int_gnt_q && !bus_cnt;

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      int_gnt_q <= 1'b0;
    end else begin
      cnt_q.we  <= 1'b0;
      int_gnt_q <= 1'b0;
      if (bus_cnt) begin
        cnt_q <= c_wr;
      end else if (int_take) begin
        cnt_q     <= make_wr(1'b1, INT_ADDR, INT_DATA);
        int_gnt_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      mod_we_q   <= 1'b0;
      stm_we_q   <= 1'b0;
      pwe_we_q   <= 1'b0;
      mod_addr_q <= '0;
      stm_addr_q <= '0;
      pwe_addr_q <= '0;
      mod_din_q  <= '0;
      stm_din_q  <= '0;
      pwe_din_q  <= '0;
      mod_seg_q  <= 1'b0;
      stm_seg_q  <= 1'b0;
      stm_page_q <= '0;
    end else begin
      mod_we_q <= 1'b0;
      stm_we_q <= 1'b0;
      pwe_we_q <= 1'b0;
      if (c_wr.we) begin
        case (c_sel)
          BRAM_SELECT_MOD: begin
            if (!mod_oob) begin
              mod_we_q   <= 1'b1;
              mod_addr_q <= {mod_seg_q, c_wr.addr[MOD_AW-1:0]};
              mod_din_q  <= c_wr.din;
            end
          end
          BRAM_SELECT_STM: begin
            stm_we_q   <= 1'b1;
            stm_addr_q <= {stm_seg_q, stm_page_q, c_wr.addr};
            stm_din_q  <= c_wr.din;
          end
          BRAM_SELECT_PWE: begin
            if (!pwe_oob) begin
              pwe_we_q   <= 1'b1;
              pwe_addr_q <= c_wr.addr[PWE_AW-1:0];
              pwe_din_q  <= c_wr.din;
            end
          end
          default: begin
            if (c_wr.addr == ADDR_MOD_MEM_WR_SEGMENT) mod_seg_q  <= c_wr.din[0];
            if (c_wr.addr == ADDR_STM_MEM_WR_SEGMENT) stm_seg_q  <= c_wr.din[0];
            if (c_wr.addr == ADDR_STM_MEM_WR_PAGE)    stm_page_q <= c_wr.din[STM_PAGE_W-1:0];
          end
        endcase
      end
    end
  end

`ifdef MEM_BUS_ADDR_CHECK_EN
  logic addr_err_q;
  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_err_q <= 1'b0;
    end else if (c_wr.we && (((c_sel == BRAM_SELECT_PWE) && pwe_oob) ||
                             ((c_sel == BRAM_SELECT_MOD) && mod_oob))) begin
      addr_err_q <= 1'b1;
    end
  end
  assign ADDR_ERR = addr_err_q;
`else
  assign ADDR_ERR = 1'b0;
`endif

  assign INT_GNT  = int_gnt_q;
  assign CNT_WE   = cnt_q.we;
  assign CNT_ADDR = cnt_q.addr;
  assign CNT_DIN  = cnt_q.din;
  assign MOD_WE   = mod_we_q;
  assign MOD_ADDR = mod_addr_q;
  assign MOD_DIN  = mod_din_q;
  assign STM_WE   = stm_we_q;
  assign STM_ADDR = stm_addr_q;
  assign STM_DIN  = stm_din_q;
  assign PWE_WE   = pwe_we_q;
  assign PWE_ADDR = pwe_addr_q;
  assign PWE_DIN  = pwe_din_q;

endmodule

// File: tb/tb_memory_bus_write_sequencer.sv
// Directed bench for memory_bus_write_sequencer; hand-computed expectations.
module tb_memory_bus_write_sequencer;
  import memory_bus_write_sequencer_pkg::*;

  logic        BUS_CLK = 1'b0;
  logic        RST_N;
  logic        EN, WE;
  logic [1:0]  BRAM_SELECT;
  logic [13:0] BRAM_ADDR;
  logic [15:0] DATA_IN;
  logic        INT_REQ;
  logic [13:0] INT_ADDR;
  logic [15:0] INT_DATA;
  logic        INT_GNT;
  logic        CNT_WE;
  logic [13:0] CNT_ADDR;
  logic [15:0] CNT_DIN;
  logic        MOD_WE;
  logic [14:0] MOD_ADDR;
  logic [15:0] MOD_DIN;
  logic        STM_WE;
  logic [18:0] STM_ADDR;
  logic [15:0] STM_DIN;
  logic        PWE_WE;
  logic [6:0]  PWE_ADDR;
  logic [15:0] PWE_DIN;
  logic        ADDR_ERR;

  memory_bus_write_sequencer dut (
    .BUS_CLK(BUS_CLK), .RST_N(RST_N), .EN(EN), .WE(WE),
    .BRAM_SELECT(BRAM_SELECT), .BRAM_ADDR(BRAM_ADDR), .DATA_IN(DATA_IN),
    .INT_REQ(INT_REQ), .INT_ADDR(INT_ADDR), .INT_DATA(INT_DATA), .INT_GNT(INT_GNT),
    .CNT_WE(CNT_WE), .CNT_ADDR(CNT_ADDR), .CNT_DIN(CNT_DIN),
    .MOD_WE(MOD_WE), .MOD_ADDR(MOD_ADDR), .MOD_DIN(MOD_DIN),
    .STM_WE(STM_WE), .STM_ADDR(STM_ADDR), .STM_DIN(STM_DIN),
    .PWE_WE(PWE_WE), .PWE_ADDR(PWE_ADDR), .PWE_DIN(PWE_DIN),
    .ADDR_ERR(ADDR_ERR)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int npass = 0;
  int ntotal = 0;
  int cnt_n, mod_n, stm_n, pwe_n, gnt_n;
  logic [13:0] cnt_a;
  logic [15:0] cnt_d, mod_d, stm_d, pwe_d;
  logic [14:0] mod_a;
  logic [18:0] stm_a;
  logic [6:0]  pwe_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic clr();
    cnt_n = 0; mod_n = 0; stm_n = 0; pwe_n = 0; gnt_n = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (CNT_WE) begin cnt_n++; cnt_a = CNT_ADDR; cnt_d = CNT_DIN; end
      if (MOD_WE) begin mod_n++; mod_a = MOD_ADDR; mod_d = MOD_DIN; end
      if (STM_WE) begin stm_n++; stm_a = STM_ADDR; stm_d = STM_DIN; end
      if (PWE_WE) begin pwe_n++; pwe_a = PWE_ADDR; pwe_d = PWE_DIN; end
      if (INT_GNT) gnt_n++;
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d);
    EN = 1'b1; WE = 1'b1; BRAM_SELECT = sel; BRAM_ADDR = a; DATA_IN = d;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d);
    drive(sel, a, d);
    run(2);
    EN = 1'b0; WE = 1'b0;
    run(4);
  endtask

  initial begin
    RST_N = 1'b0; EN = 0; WE = 0; BRAM_SELECT = 0; BRAM_ADDR = 0; DATA_IN = 0;
    INT_REQ = 0; INT_ADDR = 0; INT_DATA = 0;
    clr();
    tick(); tick();
    chk("rst_strobes", {58'd0, CNT_WE, MOD_WE, STM_WE, PWE_WE, INT_GNT, ADDR_ERR}, 64'd0);
    chk("rst_addrs", {CNT_ADDR, MOD_ADDR, STM_ADDR, PWE_ADDR}, 64'd0);
    chk("rst_dins", {CNT_DIN, MOD_DIN, STM_DIN, PWE_DIN}, 64'd0);
    RST_N = 1'b1;
    tick(); tick();

    // 1: MOD write, latency and single strobe
    drive(BRAM_SELECT_MOD, 14'd5, 16'hA55A);
    tick(); tick();
    WE = 1'b0;
    chk("t1_no_early_we", MOD_WE, 1'b0);
    tick();
    chk("t1_mod_we", MOD_WE, 1'b1);
    chk("t1_mod_addr", MOD_ADDR, 15'h0005);
    chk("t1_mod_din", MOD_DIN, 16'hA55A);
    tick();
    chk("t1_mod_we_drop", MOD_WE, 1'b0);
    EN = 1'b0;
    clr(); run(4);
    chk("t1_no_extra", mod_n, 0);

    // 2: STM segment/page shadows
    clr();
    wr(BRAM_SELECT_CONTROLLER, ADDR_STM_MEM_WR_SEGMENT, 16'h0001);
    wr(BRAM_SELECT_CONTROLLER, ADDR_STM_MEM_WR_PAGE, 16'h0003);
    chk("t2_cnt_count", cnt_n, 2);
    chk("t2_cnt_addr", cnt_a, ADDR_STM_MEM_WR_PAGE);
    chk("t2_cnt_din", cnt_d, 16'h0003);
    clr();
    wr(BRAM_SELECT_STM, 14'd10, 16'h1234);
    chk("t2_stm_count", stm_n, 1);
    chk("t2_stm_addr", stm_a, {1'b1, 4'd3, 14'd10});
    chk("t2_stm_din", stm_d, 16'h1234);
    chk("t2_no_cnt", cnt_n, 0);

    // 3: internal request collides with bus controller commit
    drive(BRAM_SELECT_CONTROLLER, 14'd2, 16'h0055);
    tick(); tick();
    EN = 1'b0; WE = 1'b0;
    INT_REQ = 1'b1; INT_ADDR = 14'd7; INT_DATA = 16'hBEEF;
    tick();
    chk("t3_bus_first", {CNT_WE, INT_GNT, CNT_ADDR, CNT_DIN}, {1'b1, 1'b0, 14'd2, 16'h0055});
    tick();
    chk("t3_int_next", {CNT_WE, INT_GNT, CNT_ADDR, CNT_DIN}, {1'b1, 1'b1, 14'd7, 16'hBEEF});
    INT_REQ = 1'b0;
    tick();
    chk("t3_idle", {CNT_WE, INT_GNT}, 2'b00);
    INT_REQ = 1'b1; INT_ADDR = 14'd9; INT_DATA = 16'h0909;
    tick();
    chk("t3_free_grant", {CNT_WE, INT_GNT, CNT_ADDR, CNT_DIN}, {1'b1, 1'b1, 14'd9, 16'h0909});
    INT_REQ = 1'b0;
    run(3);

    // 4: long hold gives one strobe; EN drop in HOLD adds none
    clr();
    drive(BRAM_SELECT_PWE, 14'd9, 16'h0077);
    run(10);
    EN = 1'b0;
    run(4);
    WE = 1'b0;
    chk("t4_pwe_count", pwe_n, 1);
    chk("t4_pwe_addr", {pwe_a, pwe_d}, {7'd9, 16'h0077});
    clr();
    drive(BRAM_SELECT_MOD, 14'd4, 16'h0044);
    run(4);
    EN = 1'b0;
    run(6);
    WE = 1'b0;
    run(2);
    chk("t4_en_drop_count", mod_n, 1);

    // 5: PWE range
    clr();
    wr(BRAM_SELECT_PWE, 14'd200, 16'h00C8);
`ifdef MEM_BUS_ADDR_CHECK_EN
    chk("t5_oob_dropped", pwe_n, 0);
    chk("t5_err_set", ADDR_ERR, 1'b1);
`else
    chk("t5_alias_count", pwe_n, 1);
    chk("t5_alias_addr", pwe_a, 7'd72);
    chk("t5_err_zero", ADDR_ERR, 1'b0);
`endif
    clr();
    wr(BRAM_SELECT_PWE, 14'd127, 16'h007F);
    chk("t5_edge_write", {pwe_n[7:0], 1'b0, pwe_a, pwe_d}, {8'd1, 1'b0, 7'd127, 16'h007F});
`ifdef MEM_BUS_ADDR_CHECK_EN
    chk("t5_err_sticky", ADDR_ERR, 1'b1);
`else
    chk("t5_err_still_zero", ADDR_ERR, 1'b0);
`endif

    // 6: reset during HOLD
    wr(BRAM_SELECT_CONTROLLER, ADDR_MOD_MEM_WR_SEGMENT, 16'h0001);
    drive(BRAM_SELECT_STM, 14'd0, 16'h0005);
    run(4);
    chk("t6_pre_stm_addr", STM_ADDR, {1'b1, 4'd3, 14'd0});
    RST_N = 1'b0;
    #1;
    chk("t6_rst_strobes", {58'd0, CNT_WE, MOD_WE, STM_WE, PWE_WE, INT_GNT, ADDR_ERR}, 64'd0);
    chk("t6_rst_addrs", {CNT_ADDR, MOD_ADDR, STM_ADDR, PWE_ADDR}, 64'd0);
    chk("t6_rst_dins", {CNT_DIN, MOD_DIN, STM_DIN, PWE_DIN}, 64'd0);
    tick(); tick();
    RST_N = 1'b1;
    clr();
    run(5);
    chk("t6_no_replay", stm_n, 0);
    EN = 1'b0; WE = 1'b0;
    run(2);
    clr();
    wr(BRAM_SELECT_STM, 14'd0, 16'h0009);
    chk("t6_stm_count", stm_n, 1);
    chk("t6_stm_addr", stm_a, 19'd0);
    chk("t6_stm_din", stm_d, 16'h0009);
    clr();
    wr(BRAM_SELECT_MOD, 14'd3, 16'h0033);
    chk("t6_mod_seg_clr", {mod_n[7:0], 1'b0, mod_a}, {8'd1, 1'b0, 15'd3});

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
